// File: rtl/debug_probe_sel.sv
// Debug probe selector: debounced key steps a 5-bit probe index and a small FSM refreshes the display word.
// Optional build macro PROBE_AUTOSCAN_EN adds a periodic auto-advance of the index.
module debug_probe_sel #(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int MEM_TIMEOUT     = 255,
   parameter int AUTOSCAN_CYCLES = 50000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        key_next_n,
   input  logic [1:0]  sw_mode,
   output logic [4:0]  rf_addr,
   input  logic [31:0] rf_rdata,
   input  logic [31:0] pc,
   input  logic [31:0] instr,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic [31:0] disp_data,
   output logic        disp_load,
   output logic [4:0]  index
);

   localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam int MT_W = $clog2(MEM_TIMEOUT + 1);
   localparam logic [MT_W-1:0] MT_LAST = MT_W'(MEM_TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, SETTLE, MEMREQ, LOAD} state_t;

   logic            keySync1_q, keySync2_q;
   logic            keyDb_q, keyDb_d;
   logic [DB_W-1:0] dbCount_q, dbCount_d;
   logic            keyFall;
   logic            stepNext;
   logic            step_q;
   logic [4:0]      index_q;
   logic [1:0]      swMode_q;
   logic            postReset_q;
   logic            refresh;
   state_t          state_q, state_d;
   logic            pending_q, pending_d;
   logic [MT_W-1:0] memTimer_q, memTimer_d;
   logic [31:0]     dispData_q, dispData_d;
   logic            dispLoad_q, dispLoad_d;
   logic [31:0]     selWord;

   // The debounced level only flips once the synchronized key has disagreed with it for DEBOUNCE_CYCLES cycles in a row.
   always_comb begin
      keyDb_d   = keyDb_q;
      dbCount_d = '0;
      if (keySync2_q != keyDb_q) begin
         if (dbCount_q == DB_LAST) begin
            keyDb_d = keySync2_q;
         end else begin
            dbCount_d = dbCount_q + DB_W'(1);
         end
      end
   end

   assign keyFall = keyDb_q & ~keyDb_d;

`ifdef PROBE_AUTOSCAN_EN
   localparam int AS_W = $clog2(AUTOSCAN_CYCLES + 1);
   localparam logic [AS_W-1:0] AS_LAST = AS_W'(AUTOSCAN_CYCLES - 1);

   logic [AS_W-1:0] scanCount_q, scanCount_d;
   logic            autoTick;

   // A key press restarts the scan period so manual stepping is never followed by an immediate auto step.
   always_comb begin
      autoTick    = 1'b0;
      scanCount_d = scanCount_q + AS_W'(1);
      if (keyFall) begin
         scanCount_d = '0;
      end else if (scanCount_q == AS_LAST) begin
         autoTick    = 1'b1;
         scanCount_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         scanCount_q <= '0;
      end else begin
         scanCount_q <= scanCount_d;
      end
   end

   assign stepNext = keyFall | autoTick;
`else
   localparam int unusedAutoscanCycles = AUTOSCAN_CYCLES;

   assign stepNext = keyFall;
`endif

   assign refresh = step_q | (sw_mode != swMode_q) | postReset_q;

   always_comb begin
      unique case (sw_mode)
         2'd0:    selWord = rf_rdata;
         2'd1:    selWord = pc;
         default: selWord = instr;
      endcase
   end

   // Refreshes seen while busy collapse into the pending flag and are replayed from LOAD.
   always_comb begin
      state_d    = state_q;
      pending_d  = pending_q;
      memTimer_d = memTimer_q;
      dispData_d = dispData_q;
      dispLoad_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (refresh || pending_q) begin
               state_d   = SETTLE;
               pending_d = 1'b0;
            end
         end
         SETTLE: begin
            if (refresh) begin
               pending_d = 1'b1;
            end
            if (sw_mode == 2'd3) begin
               state_d    = MEMREQ;
               memTimer_d = '0;
            end else begin
               state_d    = LOAD;
               dispData_d = selWord;
               dispLoad_d = 1'b1;
            end
         end
         MEMREQ: begin
            if (refresh) begin
               pending_d = 1'b1;
            end
            if (mem_ack) begin
               state_d    = LOAD;
               dispData_d = mem_rdata;
               dispLoad_d = 1'b1;
            end else if (memTimer_q == MT_LAST) begin
               state_d    = LOAD;
               dispData_d = 32'hDEADDEAD;
               dispLoad_d = 1'b1;
            end else begin
               memTimer_d = memTimer_q + MT_W'(1);
            end
         end
         LOAD: begin
            if (refresh || pending_q) begin
               state_d   = SETTLE;
               pending_d = 1'b0;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         keySync1_q  <= 1'b1;
         keySync2_q  <= 1'b1;
         keyDb_q     <= 1'b1;
         dbCount_q   <= '0;
         step_q      <= 1'b0;
         index_q     <= 5'd0;
         swMode_q    <= sw_mode;
         postReset_q <= 1'b1;
         state_q     <= IDLE;
         pending_q   <= 1'b0;
         memTimer_q  <= '0;
         dispData_q  <= 32'd0;
         dispLoad_q  <= 1'b0;
      end else begin
         keySync1_q  <= key_next_n;
         keySync2_q  <= keySync1_q;
         keyDb_q     <= keyDb_d;
         dbCount_q   <= dbCount_d;
         step_q      <= stepNext;
         index_q     <= index_q + {4'd0, step_q};
         swMode_q    <= sw_mode;
         postReset_q <= 1'b0;
         state_q     <= state_d;
         pending_q   <= pending_d;
         memTimer_q  <= memTimer_d;
         dispData_q  <= dispData_d;
         dispLoad_q  <= dispLoad_d;
      end
   end

   assign rf_addr   = index_q;
   assign index     = index_q;
   assign mem_req   = (state_q == MEMREQ);
   assign mem_addr  = {25'd0, index_q, 2'b00};
   assign disp_data = dispData_q;
   assign disp_load = dispLoad_q;

endmodule

// File: tb/tb_debug_probe_sel.sv
// Directed bench for debug_probe_sel: a scoreboard queue holds expected display words, popped on every disp_load.
// A second instance with a long memory timeout covers stepping during a long fetch.
module tb_debug_probe_sel;

   logic        clk;
   logic        reset;
   logic        keyN;
   logic [1:0]  swMode;
   logic [31:0] pc, instr;

   logic [4:0]  rfAddr, index;
   logic [31:0] rfRdata, memAddr, memRdata, dispData;
   logic        memReq, memAck, dispLoad;

   logic [4:0]  rfAddrL, indexL;
   logic [31:0] rfRdataL, memAddrL, memRdataL, dispDataL;
   logic        memReqL, memAckL, dispLoadL;

   int          vectors = 0;
   int          miscompares = 0;
   logic [31:0] expQ[$];
   logic        sbOn;

   logic        ackEnable;
   int          ackDelay;
   logic [31:0] ackData;
   int          reqCycles = 0;
   int          lastReqLen = 0;

   logic        ackLEnable;
   int          loadCountL = 0;
   logic [31:0] lastDataL = 32'd0;

   assign rfRdata  = 32'h1000_0000 + {27'd0, rfAddr};
   assign rfRdataL = 32'h1000_0000 + {27'd0, rfAddrL};

   debug_probe_sel #(.DEBOUNCE_CYCLES(8), .MEM_TIMEOUT(10), .AUTOSCAN_CYCLES(1000)) dut (
      .clk(clk), .reset(reset), .key_next_n(keyN), .sw_mode(swMode),
      .rf_addr(rfAddr), .rf_rdata(rfRdata), .pc(pc), .instr(instr),
      .mem_req(memReq), .mem_addr(memAddr), .mem_ack(memAck), .mem_rdata(memRdata),
      .disp_data(dispData), .disp_load(dispLoad), .index(index)
   );

   debug_probe_sel #(.DEBOUNCE_CYCLES(8), .MEM_TIMEOUT(255), .AUTOSCAN_CYCLES(1000)) dutL (
      .clk(clk), .reset(reset), .key_next_n(keyN), .sw_mode(swMode),
      .rf_addr(rfAddrL), .rf_rdata(rfRdataL), .pc(pc), .instr(instr),
      .mem_req(memReqL), .mem_addr(memAddrL), .mem_ack(memAckL), .mem_rdata(memRdataL),
      .disp_data(dispDataL), .disp_load(dispLoadL), .index(indexL)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Holds the key low for lowCycles, then releases it long enough for the debouncer to settle high again.
   task automatic applyStimulus(input int lowCycles);
      keyN = 1'b0;
      repeat (lowCycles) @(negedge clk);
      keyN = 1'b1;
      repeat (14) @(negedge clk);
   endtask

   task automatic waitMemReq();
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (memReq) seen = 1'b1;
      end
      checkOutput("memreq_seen", {31'd0, seen}, 32'd1);
   endtask

   // Memory model for the short-timeout instance: acks once after ackDelay request cycles.
   always @(negedge clk) begin
      if (memReq) begin
         reqCycles = reqCycles + 1;
         if (ackEnable && reqCycles == ackDelay + 1) begin
            memAck   = 1'b1;
            memRdata = ackData;
         end else begin
            memAck = 1'b0;
         end
      end else begin
         if (reqCycles != 0) lastReqLen = reqCycles;
         reqCycles = 0;
         memAck    = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (ackLEnable && memReqL && !memAckL) begin
         memAckL   = 1'b1;
         memRdataL = memAddrL;
      end else begin
         memAckL = 1'b0;
      end
      if (dispLoadL) begin
         loadCountL = loadCountL + 1;
         lastDataL  = dispDataL;
      end
   end

   always @(negedge clk) begin
      if (sbOn && !reset && dispLoad) begin
         int n;
         n = expQ.size();
         checkOutput("sb_load_expected", {31'd0, n > 0}, 32'd1);
         if (n > 0) checkOutput("sb_disp_data", dispData, expQ.pop_front());
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int baseL;
      reset = 1'b1; keyN = 1'b1; swMode = 2'd1;
      pc = 32'h0040_0010; instr = 32'h8C82_0004;
      memAck = 1'b0; memRdata = 32'd0; memAckL = 1'b0; memRdataL = 32'd0;
      ackEnable = 1'b0; ackDelay = 0; ackData = 32'd0; ackLEnable = 1'b0;
      sbOn = 1'b1;

      repeat (3) @(negedge clk);
      checkOutput("reset_disp_load", {31'd0, dispLoad}, 32'd0);
      checkOutput("reset_disp_data", dispData, 32'd0);
      checkOutput("reset_index", {27'd0, index}, 32'd0);
      checkOutput("reset_mem_req", {31'd0, memReq}, 32'd0);

      // Post-reset refresh in PC mode lands exactly two cycles after release.
      expQ.push_back(32'h0040_0010);
      reset = 1'b0;
      @(negedge clk);
      checkOutput("rst_refresh_early", {31'd0, dispLoad}, 32'd0);
      @(negedge clk);
      checkOutput("rst_refresh_load", {31'd0, dispLoad}, 32'd1);
      checkOutput("rst_refresh_index", {27'd0, index}, 32'd0);
      repeat (4) @(negedge clk);

      expQ.push_back(32'h1000_0000);
      swMode = 2'd0;
      repeat (6) @(negedge clk);
      applyStimulus(3);
      checkOutput("glitch_no_step", {27'd0, index}, 32'd0);
      expQ.push_back(32'h1000_0001);
      applyStimulus(20);
      checkOutput("hold_one_step", {27'd0, index}, 32'd1);
      checkOutput("hold_rf_addr", {27'd0, rfAddr}, 32'd1);
      for (int i = 2; i <= 5; i++) begin
         expQ.push_back(32'h1000_0000 + 32'(i));
         applyStimulus(12);
      end
      checkOutput("index_five", {27'd0, index}, 32'd5);

      // Memory word fetch acknowledged on the fifth request cycle.
      ackEnable = 1'b1; ackDelay = 4; ackData = 32'hCAFE_F00D;
      expQ.push_back(32'hCAFE_F00D);
      swMode = 2'd3;
      waitMemReq();
      checkOutput("mem_addr_idx5", memAddr, 32'h0000_0014);
      repeat (12) @(negedge clk);
      checkOutput("ack_req_len", lastReqLen, 32'd5);
      ackEnable = 1'b0;

      expQ.push_back(32'h8C82_0004);
      swMode = 2'd2;
      repeat (6) @(negedge clk);
      expQ.push_back(32'hDEAD_DEAD);
      swMode = 2'd3;
      repeat (18) @(negedge clk);
      checkOutput("timeout_req_len", lastReqLen, 32'd10);

      // Reset during a fetch must abort it silently; only the post-reset refresh may load.
      expQ.push_back(32'h1000_0005);
      swMode = 2'd0;
      repeat (6) @(negedge clk);
      swMode = 2'd3;
      waitMemReq();
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      checkOutput("abort_mem_req", {31'd0, memReq}, 32'd0);
      checkOutput("abort_disp_load", {31'd0, dispLoad}, 32'd0);
      repeat (2) @(negedge clk);
      checkOutput("abort_index", {27'd0, index}, 32'd0);
      expQ.push_back(32'hDEAD_DEAD);
      reset = 1'b0;
      repeat (16) @(negedge clk);
      checkOutput("sb_drained", 32'(expQ.size()), 32'd0);

      sbOn = 1'b0;
      swMode = 2'd1;
      repeat (300) @(negedge clk);
      for (int i = 0; i < 31; i++) applyStimulus(12);
      checkOutput("wrap_index31", {27'd0, indexL}, 32'd31);
      repeat (10) @(negedge clk);

      // Two steps while the long-timeout instance waits on a fetch; both collapse into one replay.
      baseL = loadCountL;
      swMode = 2'd3;
      applyStimulus(12);
      applyStimulus(12);
      checkOutput("wrap_mid_req", {31'd0, memReqL}, 32'd1);
      ackLEnable = 1'b1;
      repeat (12) @(negedge clk);
      checkOutput("wrap_index1", {27'd0, indexL}, 32'd1);
      checkOutput("wrap_load_count", 32'(loadCountL - baseL), 32'd2);
      checkOutput("wrap_last_word", lastDataL, 32'h0000_0004);
      checkOutput("wrap_dut_index", {27'd0, index}, 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
